pipelined_mdu_alu: RTL and testbench
====================================

Name: pipelined_mdu_alu

Overview:
- Registered, parametrised ALU for the MIPS datapath, successor of the single-cycle combinational ALU.
- Keeps the existing 4-bit operation encoding and adds signed SLT, SRA, and iterative unsigned multiply/divide with HI/LO registers.
- Uses a valid/ready handshake, so the hazard/stall logic can hold the pipeline while a multi-cycle MULTU/DIVU runs.
- Sits in the EX stage between the operand muxes and the EX/MEM register.

Parameters:
- WIDTH, 32, data width of operands, result, HI and LO (even, ≥8).
- SHAMT_W, $clog2(WIDTH), width of the shift-amount field.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- valid_i  in  1  operation and operands present this cycle.
- ready_o  out  1  block can accept an operation this cycle.
- alu_operation_i  in  4  operation code.
- a_i  in  WIDTH  operand A (rs).
- b_i  in  WIDTH  operand B (rt/immediate).
- shamt_i  in  SHAMT_W  shift amount.
- valid_o  out  1  one-cycle pulse: alu_data_o, zero_o, topc_o, dbz_o are valid.
- alu_data_o  out  WIDTH  registered result.
- zero_o  out  1  alu_data_o == 0, registered with the result.
- topc_o  out  1  operation was NOTANDPC (jr path).
- dbz_o  out  1  last DIVU had divisor 0 (sticky until next DIVU).
- hi_o  out  WIDTH  HI register.
- lo_o  out  WIDTH  LO register.

Behaviour:
- Opcodes:
  - SUB 0001, OR 0010, ADD 0011, LUI 0100, SLL 0101, SRL 0110, AND 0111, NOR 1000, NOTHING 1001, NOTANDPC 1010 (pass a_i; topc_o=1).
  - MULTU 1011, DIVU 1100, SLT 1101 (signed, result 1/0), SRA 1110 (arithmetic shift of b_i), MFLO 1111 (result=LO).
  - MFHI is NOTHING with a_i driven from hi_o by the datapath.
  - Opcode 0000 is undefined: result 0.
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH.
  - LUI = {b_i[WIDTH/2-1:0], WIDTH/2 zeros}.
  - Shifts use shamt_i only.
- Accept occurs on a rising edge with valid_i && ready_o. Inputs are ignored at any other time.
- FSM states: IDLE, MUL, DIV, DONE. ready_o=1 only in IDLE.
- IDLE, single-cycle op accepted: register result, zero and topc. valid_o=1 in the next cycle (latency 1). State stays IDLE, so back-to-back accepts give valid_o every cycle.
- IDLE, MULTU accepted: latch operands, count=WIDTH, state goes to MUL.
- IDLE, DIVU accepted: latch operands, count=WIDTH, state goes to DIV.
- MUL: one shift-add step per cycle, 2·WIDTH-bit accumulator.
- DIV: one restoring step per cycle.
- MUL/DIV exit: after WIDTH steps, write HI/LO and go to DONE.
  - MUL: HI=product[2W-1:W], LO=product[W-1:0].
  - DIV: LO=quotient, HI=remainder.
- DONE: valid_o=1, alu_data_o=LO, zero_o=(LO==0). Next state is IDLE.
- MULTU/DIVU latency: valid_o asserts WIDTH+1 cycles after the accept edge; ready_o returns the following cycle.
- DIVU with b_i=0: still takes WIDTH+1 cycles. Result LO=all ones, HI=a_i, dbz_o=1. Any non-zero DIVU clears dbz_o.
- MFLO accepted in the IDLE cycle right after DONE returns the new LO.
- HI/LO change only on MULTU/DIVU completion.
- Reset, at any time including mid-MUL/DIV:
  - Next cycle: state IDLE, ready_o=1.
  - valid_o, alu_data_o, zero_o, topc_o, dbz_o, hi_o and lo_o all 0.
  - The in-flight operation is discarded; no valid_o for it.
  - reset has priority over valid_i.

Decomposition:
- Shared package alu_pkg holds:
  - the opcode localparams (the existing ten plus MULTU, DIVU, SLT, SRA, MFLO);
  - the FSM state encoding;
  - a helper function for the LUI half-width.
- One sub-module: mdu_iter (WIDTH param). It owns the operand latches, step counter, accumulator/remainder logic and the HI/LO update, with start/busy/done/dbz signals.
- The top level holds the combinational single-cycle datapath, the output registers and the handshake.

Test Plan (WIDTH=32):
- ADD 0x7FFFFFFF+1 with valid_i held 3 cycles (SUB 5-5, then SLT 0xFFFFFFFF vs 1) -> valid_o on 3 consecutive cycles: 0x80000000 (zero_o=0), 0x00000000 (zero_o=1), 0x00000001.
- MULTU 0xFFFFFFFF×0xFFFFFFFF -> ready_o low 33 cycles; valid_o pulse 33 cycles after accept with HI=0xFFFFFFFE, LO=0x00000001, alu_data_o=0x00000001; then MFLO returns 0x00000001.
- DIVU 100/7 -> LO=14, HI=2, dbz_o=0. Then DIVU 9/0 -> LO=0xFFFFFFFF, HI=9, dbz_o=1, latency 33.
- SRA 0x80000010 by 4 -> 0xF8000001. SRL same -> 0x08000001. LUI b=0x1234ABCD -> 0xABCD0000. NOTANDPC a=0x400 -> data 0x400, topc_o=1.
- Reset asserted 10 cycles into MULTU 6×7 -> next cycle ready_o=1 and hi_o=lo_o=0, no valid_o within 40 cycles. A new MULTU 6×7 then gives LO=42, HI=0.
- valid_i high while busy with changing operands -> no extra accept, and the original MULTU result is unaffected.

Source files
------------

// File: rtl/pipelined_mdu_alu_pkg.sv
// Shared definitions for the pipelined MIPS ALU: opcodes, FSM encoding and
// the LUI helper.
package alu_pkg;

    // Operation codes. The first ten match the original single-cycle ALU.
    localparam logic [3:0] OP_UNDEF    = 4'b0000;
    localparam logic [3:0] OP_SUB      = 4'b0001;
    localparam logic [3:0] OP_OR       = 4'b0010;
    localparam logic [3:0] OP_ADD      = 4'b0011;
    localparam logic [3:0] OP_LUI      = 4'b0100;
    localparam logic [3:0] OP_SLL      = 4'b0101;
    localparam logic [3:0] OP_SRL      = 4'b0110;
    localparam logic [3:0] OP_AND      = 4'b0111;
    localparam logic [3:0] OP_NOR      = 4'b1000;
    localparam logic [3:0] OP_NOTHING  = 4'b1001;
    localparam logic [3:0] OP_NOTANDPC = 4'b1010;
    localparam logic [3:0] OP_MULTU    = 4'b1011;
    localparam logic [3:0] OP_DIVU     = 4'b1100;
    localparam logic [3:0] OP_SLT      = 4'b1101;
    localparam logic [3:0] OP_SRA      = 4'b1110;
    localparam logic [3:0] OP_MFLO     = 4'b1111;

    // Handshake / sequencing FSM encoding.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Widest datapath the LUI helper supports; callers truncate to WIDTH.
    localparam int LUI_MAX_W = 128;

    // Moves the low half of b into the upper half of a width-bit word,
    // clearing the low half and everything above width.
    function automatic logic [LUI_MAX_W-1:0] lui_value(
        input logic [LUI_MAX_W-1:0] b,
        input int                   width
    );
        logic [LUI_MAX_W-1:0] mask;
        mask = ~({LUI_MAX_W{1'b1}} << width);
        return (b << (width >> 1)) & mask;
    endfunction

endpackage

// File: rtl/pipelined_mdu_alu_if.sv
// Operation/result bundle between the EX-stage operand muxes and the ALU.
interface pipelined_mdu_alu_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
);
    logic               valid_i;
    logic               ready_o;
    logic [3:0]         alu_operation_i;
    logic [WIDTH-1:0]   a_i;
    logic [WIDTH-1:0]   b_i;
    logic [SHAMT_W-1:0] shamt_i;
    logic               valid_o;
    logic [WIDTH-1:0]   alu_data_o;
    logic               zero_o;
    logic               topc_o;
    logic               dbz_o;
    logic [WIDTH-1:0]   hi_o;
    logic [WIDTH-1:0]   lo_o;

    // Datapath side: issues operations, consumes results.
    modport master (
        output valid_i, alu_operation_i, a_i, b_i, shamt_i,
        input  ready_o, valid_o, alu_data_o, zero_o, topc_o, dbz_o, hi_o, lo_o
    );

    // ALU side.
    modport slave (
        input  valid_i, alu_operation_i, a_i, b_i, shamt_i,
        output ready_o, valid_o, alu_data_o, zero_o, topc_o, dbz_o, hi_o, lo_o
    );
endinterface

// File: rtl/pipelined_mdu_alu_mdu_iter.sv
// Iterative unsigned multiply/divide unit: one shift-add or restoring step
// per cycle, owns HI/LO and the divide-by-zero flag.
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic             div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] res_lo_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             dbz_o
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    // acc_q upper half: partial product / remainder;
    // acc_q lower half: multiplier being consumed / quotient being built.
    logic                   busy_q;
    logic                   div_q;
    logic [CNT_W-1:0]       count_q;
    logic [WIDTH-1:0]       mcand_q;
    logic [2*WIDTH-1:0]     acc_q;
    logic [2*WIDTH-1:0]     acc_d;
    logic [WIDTH-1:0]       hi_q;
    logic [WIDTH-1:0]       lo_q;
    logic                   dbz_q;

    logic [WIDTH:0]         sum_s;
    logic [WIDTH:0]         shifted_s;
    logic [WIDTH-1:0]       diff_s;
    logic                   ge_s;

    // One multiply or divide step computed from the current accumulator.
    always_comb begin
        sum_s     = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                  + (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        shifted_s = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        // Only the low bits matter: when shifted >= divisor the true
        // difference is below the divisor and therefore fits WIDTH bits.
        diff_s    = shifted_s[WIDTH-1:0] - mcand_q;
        ge_s      = (shifted_s >= {1'b0, mcand_q});
        if (div_q) begin
            if (ge_s) begin
                acc_d = {diff_s, acc_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_d = {shifted_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_d = {sum_s, acc_q[WIDTH-1:1]};
        end
    end

    // Operand latch, step counter and HI/LO/dbz update on completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q  <= 1'b0;
            div_q   <= 1'b0;
            count_q <= {CNT_W{1'b0}};
            mcand_q <= {WIDTH{1'b0}};
            acc_q   <= {(2*WIDTH){1'b0}};
            hi_q    <= {WIDTH{1'b0}};
            lo_q    <= {WIDTH{1'b0}};
            dbz_q   <= 1'b0;
        end else if (start_i && !busy_q) begin
            busy_q  <= 1'b1;
            div_q   <= div_i;
            count_q <= CNT_W'(WIDTH);
            // Divide keeps the divisor, multiply the multiplicand.
            mcand_q <= div_i ? b_i : a_i;
            acc_q   <= {{WIDTH{1'b0}}, (div_i ? a_i : b_i)};
        end else if (busy_q) begin
            if (count_q != {CNT_W{1'b0}}) begin
                acc_q   <= acc_d;
                count_q <= count_q - CNT_W'(1);
            end else begin
                busy_q <= 1'b0;
                hi_q   <= acc_q[2*WIDTH-1:WIDTH];
                lo_q   <= acc_q[WIDTH-1:0];
                if (div_q) begin
                    dbz_q <= (mcand_q == {WIDTH{1'b0}});
                end else begin
                    dbz_q <= dbz_q;
                end
            end
        end else begin
            busy_q <= busy_q;
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = busy_q && (count_q == {CNT_W{1'b0}});
    assign res_lo_o = acc_q[WIDTH-1:0];
    assign hi_o     = hi_q;
    assign lo_o     = lo_q;
    assign dbz_o    = dbz_q;

endmodule

// File: rtl/pipelined_mdu_alu.sv
// Registered EX-stage ALU with valid/ready handshake; single-cycle ops
// complete in one cycle, MULTU/DIVU run in the iterative unit.
module pipelined_mdu_alu #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               reset,
    pipelined_mdu_alu_if.slave bus
);
    import alu_pkg::*;

    logic [1:0]         state_q, state_d;
    logic               valid_q, valid_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               zero_q, zero_d;
    logic               topc_q, topc_d;

    logic [SHAMT_W-1:0] shamt_s;
    logic [WIDTH-1:0]   single_s;
    logic [WIDTH-1:0]   sra_s;
    logic [WIDTH-1:0]   lui_s;
    logic               slt_s;
    logic               accept_s;
    logic               mdu_start_s;
    logic               mdu_div_s;
    logic               mdu_busy_s;
    logic               mdu_done_s;
    logic [WIDTH-1:0]   mdu_res_lo_s;
    logic [WIDTH-1:0]   hi_s;
    logic [WIDTH-1:0]   lo_s;
    logic               dbz_s;

    assign shamt_s  = bus.shamt_i;
    assign sra_s    = $unsigned($signed(bus.b_i) >>> shamt_s);
    assign slt_s    = ($signed(bus.a_i) < $signed(bus.b_i));
    assign lui_s    = WIDTH'(lui_value(LUI_MAX_W'(bus.b_i), WIDTH));
    assign accept_s = bus.valid_i && (state_q == ST_IDLE);

    // Combinational result of every single-cycle operation.
    always_comb begin
        single_s = {WIDTH{1'b0}};
        case (bus.alu_operation_i)
            OP_SUB:      single_s = bus.a_i - bus.b_i;
            OP_OR:       single_s = bus.a_i | bus.b_i;
            OP_ADD:      single_s = bus.a_i + bus.b_i;
            OP_LUI:      single_s = lui_s;
            OP_SLL:      single_s = bus.b_i << shamt_s;
            OP_SRL:      single_s = bus.b_i >> shamt_s;
            OP_AND:      single_s = bus.a_i & bus.b_i;
            OP_NOR:      single_s = ~(bus.a_i | bus.b_i);
            OP_NOTHING:  single_s = bus.a_i;
            OP_NOTANDPC: single_s = bus.a_i;
            OP_SLT:      single_s = {{(WIDTH-1){1'b0}}, slt_s};
            OP_SRA:      single_s = sra_s;
            OP_MFLO:     single_s = lo_s;
            default:     single_s = {WIDTH{1'b0}};
        endcase
    end

    // Handshake FSM and next values of the output registers.
    always_comb begin
        state_d     = state_q;
        valid_d     = 1'b0;
        data_d      = data_q;
        zero_d      = zero_q;
        topc_d      = topc_q;
        mdu_start_s = 1'b0;
        mdu_div_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    if (bus.alu_operation_i == OP_MULTU) begin
                        state_d     = ST_MUL;
                        mdu_start_s = 1'b1;
                        mdu_div_s   = 1'b0;
                    end else if (bus.alu_operation_i == OP_DIVU) begin
                        state_d     = ST_DIV;
                        mdu_start_s = 1'b1;
                        mdu_div_s   = 1'b1;
                    end else begin
                        valid_d = 1'b1;
                        data_d  = single_s;
                        zero_d  = (single_s == {WIDTH{1'b0}});
                        topc_d  = (bus.alu_operation_i == OP_NOTANDPC);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL, ST_DIV: begin
                // The completing step publishes the new LO as the result.
                if (mdu_done_s) begin
                    state_d = ST_DONE;
                    valid_d = 1'b1;
                    data_d  = mdu_res_lo_s;
                    zero_d  = (mdu_res_lo_s == {WIDTH{1'b0}});
                    topc_d  = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output registers and FSM state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            data_q  <= {WIDTH{1'b0}};
            zero_q  <= 1'b0;
            topc_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            zero_q  <= zero_d;
            topc_q  <= topc_d;
        end
    end

    mdu_iter #(
        .WIDTH (WIDTH)
    ) u_mdu (
        .clk      (clk),
        .reset    (reset),
        .start_i  (mdu_start_s),
        .div_i    (mdu_div_s),
        .a_i      (bus.a_i),
        .b_i      (bus.b_i),
        .busy_o   (mdu_busy_s),
        .done_o   (mdu_done_s),
        .res_lo_o (mdu_res_lo_s),
        .hi_o     (hi_s),
        .lo_o     (lo_s),
        .dbz_o    (dbz_s)
    );

    assign bus.ready_o    = (state_q == ST_IDLE) && !mdu_busy_s;
    assign bus.valid_o    = valid_q;
    assign bus.alu_data_o = data_q;
    assign bus.zero_o     = zero_q;
    assign bus.topc_o     = topc_q;
    assign bus.dbz_o      = dbz_s;
    assign bus.hi_o       = hi_s;
    assign bus.lo_o       = lo_s;

endmodule

// File: tb/tb_pipelined_mdu_alu.sv
// Self-checking bench for pipelined_mdu_alu (WIDTH=32): vector table for the
// single-cycle ops, scoreboard queue for results, hand sequences for MDU.
module tb_pipelined_mdu_alu;
    import alu_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    pipelined_mdu_alu_if #(.WIDTH(W)) bus();

    pipelined_mdu_alu #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string       name;
        logic [31:0] data;
        logic        zero;
        logic        topc;
        logic        mdu;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [31:0] data;
        logic        zero;
        logic        topc;
    } vec_t;

    exp_t        sb[$];
    vec_t        vt[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] mdl_hi = 32'd0;
    logic [31:0] mdl_lo = 32'd0;
    logic        mdl_dbz = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    // Pops and compares one result whenever valid_o is high.
    task automatic collect();
        exp_t e;
        if (bus.valid_o === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 32'(bus.valid_o), 32'd0);
            end else begin
                e = sb.pop_front();
                chk({e.name, "_data"}, bus.alu_data_o, e.data);
                chk({e.name, "_zero"}, 32'(bus.zero_o), 32'(e.zero));
                chk({e.name, "_topc"}, 32'(bus.topc_o), 32'(e.topc));
                if (e.mdu) begin
                    chk({e.name, "_hi"}, bus.hi_o, e.hi);
                    chk({e.name, "_lo"}, bus.lo_o, e.lo);
                    chk({e.name, "_dbz"}, 32'(bus.dbz_o), 32'(e.dbz));
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        collect();
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input exp_t e);
        bus.valid_i         = 1'b1;
        bus.alu_operation_i = op;
        bus.a_i             = a;
        bus.b_i             = b;
        bus.shamt_i         = sh;
        if (bus.ready_o === 1'b1 && reset === 1'b0) sb.push_back(e);
    endtask

    // Reference MULTU/DIVU result; also advances the HI/LO/dbz model.
    function automatic exp_t mdu_exp(input string name, input logic [3:0] op,
                                     input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [63:0] prod;
        if (op == OP_MULTU) begin
            prod   = {32'd0, a} * {32'd0, b};
            mdl_hi = prod[63:32];
            mdl_lo = prod[31:0];
        end else if (b == 32'd0) begin
            mdl_hi  = a;
            mdl_lo  = 32'hFFFF_FFFF;
            mdl_dbz = 1'b1;
        end else begin
            mdl_hi  = a % b;
            mdl_lo  = a / b;
            mdl_dbz = 1'b0;
        end
        e.name = name; e.data = mdl_lo; e.zero = (mdl_lo == 32'd0); e.topc = 1'b0;
        e.mdu = 1'b1; e.hi = mdl_hi; e.lo = mdl_lo; e.dbz = mdl_dbz;
        return e;
    endfunction

    function automatic exp_t plain_exp(input string name, input logic [31:0] d, input logic t);
        exp_t e;
        e.name = name; e.data = d; e.zero = (d == 32'd0); e.topc = t;
        e.mdu = 1'b0; e.hi = 32'd0; e.lo = 32'd0; e.dbz = 1'b0;
        return e;
    endfunction

    // Runs one MULTU/DIVU, checking latency, ready_o and the result.
    task automatic run_mdu(input string name, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input bit hold_busy);
        exp_t e;
        int   lat;
        bit   rdy_bad;
        e = mdu_exp(name, op, a, b);
        issue(op, a, b, 5'd0, e);
        @(posedge clk);
        #1;
        lat     = 0;
        rdy_bad = 1'b0;
        while (bus.valid_o !== 1'b1 && lat < 40) begin
            if (bus.ready_o !== 1'b0) rdy_bad = 1'b1;
            if (hold_busy) begin
                bus.valid_i         = 1'b1;
                bus.alu_operation_i = lat[0] ? OP_ADD : OP_MULTU;
                bus.a_i             = $urandom;
                bus.b_i             = $urandom;
            end else begin
                bus.valid_i = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        bus.valid_i = 1'b0;
        chk({name, "_latency"}, 32'(lat), 32'd33);
        chk({name, "_ready_low"}, 32'(rdy_bad), 32'd0);
        chk({name, "_ready_done"}, 32'(bus.ready_o), 32'd0);
        collect();
        step();
        chk({name, "_ready_back"}, 32'(bus.ready_o), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   nv;
        exp_t e;

        vt.push_back('{"add_ovf",  OP_ADD,      32'h7FFF_FFFF, 32'h0000_0001, 5'd0,  32'h8000_0000, 1'b0, 1'b0});
        vt.push_back('{"sub_eq",   OP_SUB,      32'h0000_0005, 32'h0000_0005, 5'd0,  32'h0000_0000, 1'b1, 1'b0});
        vt.push_back('{"slt_neg",  OP_SLT,      32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0001, 1'b0, 1'b0});
        vt.push_back('{"sra",      OP_SRA,      32'hFFFF_FFFF, 32'h8000_0010, 5'd4,  32'hF800_0001, 1'b0, 1'b0});
        vt.push_back('{"srl",      OP_SRL,      32'hFFFF_FFFF, 32'h8000_0010, 5'd4,  32'h0800_0001, 1'b0, 1'b0});
        vt.push_back('{"lui",      OP_LUI,      32'hFFFF_FFFF, 32'h1234_ABCD, 5'd0,  32'hABCD_0000, 1'b0, 1'b0});
        vt.push_back('{"notandpc", OP_NOTANDPC, 32'h0000_0400, 32'h0000_0000, 5'd0,  32'h0000_0400, 1'b0, 1'b1});
        vt.push_back('{"sll31",    OP_SLL,      32'hFFFF_FFFF, 32'h0000_0003, 5'd31, 32'h8000_0000, 1'b0, 1'b0});
        vt.push_back('{"or",       OP_OR,       32'h0000_F0F0, 32'h0000_0F0F, 5'd0,  32'h0000_FFFF, 1'b0, 1'b0});
        vt.push_back('{"and",      OP_AND,      32'hFF00_FF00, 32'h0FF0_0FF0, 5'd0,  32'h0F00_0F00, 1'b0, 1'b0});
        vt.push_back('{"nor",      OP_NOR,      32'h0000_0000, 32'h0000_0000, 5'd0,  32'hFFFF_FFFF, 1'b0, 1'b0});
        vt.push_back('{"nothing",  OP_NOTHING,  32'hDEAD_BEEF, 32'h0000_0001, 5'd0,  32'hDEAD_BEEF, 1'b0, 1'b0});
        vt.push_back('{"undef",    OP_UNDEF,    32'h0000_0123, 32'h0000_0456, 5'd0,  32'h0000_0000, 1'b1, 1'b0});
        vt.push_back('{"slt_pos",  OP_SLT,      32'h0000_0001, 32'hFFFF_FFFF, 5'd0,  32'h0000_0000, 1'b1, 1'b0});
        vt.push_back('{"mflo_rst", OP_MFLO,     32'h1111_1111, 32'h2222_2222, 5'd0,  32'h0000_0000, 1'b1, 1'b0});
        vt.push_back('{"add_wrap", OP_ADD,      32'hFFFF_FFFF, 32'h0000_0002, 5'd0,  32'h0000_0001, 1'b0, 1'b0});
        vt.push_back('{"sub_neg",  OP_SUB,      32'h0000_0000, 32'h0000_0001, 5'd0,  32'hFFFF_FFFF, 1'b0, 1'b0});
        vt.push_back('{"sra_pos",  OP_SRA,      32'h0000_0000, 32'h7000_0000, 5'd28, 32'h0000_0007, 1'b0, 1'b0});

        reset               = 1'b1;
        bus.valid_i         = 1'b0;
        bus.alu_operation_i = 4'd0;
        bus.a_i             = 32'd0;
        bus.b_i             = 32'd0;
        bus.shamt_i         = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_ready", 32'(bus.ready_o), 32'd1);
        chk("rst_valid", 32'(bus.valid_o), 32'd0);
        chk("rst_data",  bus.alu_data_o, 32'd0);
        chk("rst_hi",    bus.hi_o, 32'd0);
        chk("rst_lo",    bus.lo_o, 32'd0);
        chk("rst_dbz",   32'(bus.dbz_o), 32'd0);

        // Back-to-back single-cycle ops: one valid_o per cycle.
        for (int i = 0; i < vt.size(); i++) begin
            issue(vt[i].op, vt[i].a, vt[i].b, vt[i].sh,
                  plain_exp(vt[i].name, vt[i].data, vt[i].topc));
            step();
            chk({vt[i].name, "_valid"}, 32'(bus.valid_o), 32'd1);
            chk({vt[i].name, "_zero_tbl"}, 32'(bus.zero_o), 32'(vt[i].zero));
        end
        bus.valid_i = 1'b0;
        step();
        chk("idle_no_valid", 32'(bus.valid_o), 32'd0);

        run_mdu("divu_100_7", OP_DIVU, 32'd100, 32'd7, 1'b0);
        run_mdu("divu_9_0",   OP_DIVU, 32'd9,   32'd0, 1'b0);

        // dbz stays set and HI/LO hold across a single-cycle op.
        issue(OP_ADD, 32'd1, 32'd2, 5'd0, plain_exp("add_after_dbz", 32'd3, 1'b0));
        step();
        bus.valid_i = 1'b0;
        chk("dbz_sticky", 32'(bus.dbz_o), 32'd1);
        chk("hi_hold", bus.hi_o, 32'd9);
        chk("lo_hold", bus.lo_o, 32'hFFFF_FFFF);

        // MULTU with valid_i held and operands changing while busy.
        run_mdu("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        issue(OP_MFLO, 32'd0, 32'd0, 5'd0, plain_exp("mflo_mul", mdl_lo, 1'b0));
        step();
        bus.valid_i = 1'b0;
        chk("mflo_valid", 32'(bus.valid_o), 32'd1);
        step();

        // Reset ten cycles into a MULTU, with a competing valid_i.
        bus.valid_i         = 1'b1;
        bus.alu_operation_i = OP_MULTU;
        bus.a_i             = 32'd6;
        bus.b_i             = 32'd7;
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset               = 1'b1;
        bus.valid_i         = 1'b1;
        bus.alu_operation_i = OP_ADD;
        bus.a_i             = 32'd1;
        bus.b_i             = 32'd1;
        @(posedge clk);
        #1;
        reset       = 1'b0;
        bus.valid_i = 1'b0;
        mdl_hi = 32'd0; mdl_lo = 32'd0; mdl_dbz = 1'b0;
        chk("mrst_ready", 32'(bus.ready_o), 32'd1);
        chk("mrst_valid", 32'(bus.valid_o), 32'd0);
        chk("mrst_data",  bus.alu_data_o, 32'd0);
        chk("mrst_hi",    bus.hi_o, 32'd0);
        chk("mrst_lo",    bus.lo_o, 32'd0);
        chk("mrst_dbz",   32'(bus.dbz_o), 32'd0);
        nv = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.valid_o === 1'b1) nv++;
        end
        chk("mrst_no_valid", 32'(nv), 32'd0);

        run_mdu("multu_6x7", OP_MULTU, 32'd6, 32'd7, 1'b0);
        chk("mul42_lo", bus.lo_o, 32'd42);
        chk("mul42_hi", bus.hi_o, 32'd0);

        step();
        chk("sb_empty", 32'(sb.size()), 32'd0);
        while (sb.size() > 0) e = sb.pop_front();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
